// File: rtl/rrip_victim_sequencer_if.sv
// ---------------------------------------------------------------------------
// rrip_victim_sequencer_if
//   Bundle between the cache controller / SHiP predictor side (master) and
//   the RRIP victim sequencer (slave).
//
//   hit_valid, hit_index, hit_way   : cache hit notification (master -> slave)
//   miss_req, miss_index, ins_rrpv  : victim request + insertion RRPV
//   miss_ready                      : sequencer idle, miss_req accepted
//   victim_valid, victim_way        : one-cycle victim result pulse
//   busy                            : sequencer not idle
// ---------------------------------------------------------------------------
interface rrip_victim_sequencer_if #(
    parameter int SET_SIZE    = 2,
    parameter int INDEX_WIDTH = 6,
    parameter int M           = 2
);
    logic                   hit_valid;
    logic [INDEX_WIDTH-1:0] hit_index;
    logic [SET_SIZE-1:0]    hit_way;
    logic                   miss_req;
    logic [INDEX_WIDTH-1:0] miss_index;
    logic [M-1:0]           ins_rrpv;
    logic                   miss_ready;
    logic                   victim_valid;
    logic [SET_SIZE-1:0]    victim_way;
    logic                   busy;

    modport master (
        output hit_valid, hit_index, hit_way, miss_req, miss_index, ins_rrpv,
        input  miss_ready, victim_valid, victim_way, busy
    );

    modport slave (
        input  hit_valid, hit_index, hit_way, miss_req, miss_index, ins_rrpv,
        output miss_ready, victim_valid, victim_way, busy
    );
endinterface

// File: rtl/rrip_victim_sequencer.sv
// ---------------------------------------------------------------------------
// rrip_victim_sequencer
//   Owns the M-bit RRPV array for every set/way of a set-associative cache and
//   selects a victim way on a miss using the RRIP scan/age loop. The chosen
//   way is loaded with the insertion RRPV supplied by the SHiP predictor.
//   Hits promote the hit way to IMMEDIATE (0) in any FSM state.
//
//   Ports:
//     clk    : clock
//     rst_n  : synchronous, active-low reset (all RRPVs -> DISTANT, FSM idle)
//     bus    : rrip_victim_sequencer_if.slave (hit, miss request, victim out)
//
//   Timing: a miss accepted in cycle T reports its victim in T+2+2k
//   (k = aging rounds) and the sequencer is ready again in T+3+2k.
// ---------------------------------------------------------------------------
module rrip_victim_sequencer #(
    parameter int ASSOCIATIVITY = 4,
    parameter int SET_SIZE      = 2,
    parameter int DEPTH         = 64,
    parameter int INDEX_WIDTH   = 6,
    parameter int M             = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    rrip_victim_sequencer_if.slave  bus
);

    localparam logic [M-1:0] DISTANT   = '1;
    localparam logic [M-1:0] IMMEDIATE = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        AGE     = 2'd2,
        INSTALL = 2'd3
    } state_t;

    state_t state, state_nxt;

    // RRPV storage: one packed row of ways per set.
    logic [ASSOCIATIVITY-1:0][M-1:0] rrpv [DEPTH];

    // Request context captured at acceptance; the requester may change its
    // inputs freely afterwards.
    logic [INDEX_WIDTH-1:0] lat_index;
    logic [M-1:0]           lat_rrpv;
    logic [SET_SIZE-1:0]    lat_way;

    logic                      accept;
    logic [ASSOCIATIVITY-1:0]  distant_vec;
    logic                      found;
    logic [SET_SIZE-1:0]       found_way;

    assign accept = bus.miss_req && (state == IDLE);

    // ------------------------------------------------------------------
    // Scan of the latched set: per-way DISTANT match, then lowest index.
    // ------------------------------------------------------------------
    for (genvar w = 0; w < ASSOCIATIVITY; w++) begin : g_way_match
        assign distant_vec[w] = (rrpv[lat_index][w] == DISTANT);
    end

    assign found = |distant_vec;

    always_comb begin
        found_way = '0;
        // Walk downward so the lowest matching way is the last assignment.
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (distant_vec[w]) begin
                found_way = SET_SIZE'(w);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    state_nxt = found ? INSTALL : AGE;
            AGE:     state_nxt = SCAN;
            INSTALL: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request context
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lat_index <= '0;
            lat_rrpv  <= '0;
            lat_way   <= '0;
        end else begin
            if (accept) begin
                lat_index <= bus.miss_index;
                lat_rrpv  <= bus.ins_rrpv;
            end
            if (state == SCAN && found) begin
                lat_way <= found_way;
            end
        end
    end

    // ------------------------------------------------------------------
    // RRPV array update. Statement order sets priority on collisions:
    // aging < hit promotion < install. So a hit during AGE keeps the hit
    // way at IMMEDIATE while the rest of the set ages, and an install on
    // the same way as a concurrent hit keeps the insertion value.
    // Aging never wraps: AGE is only entered when no way is DISTANT.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) begin
                rrpv[s] <= {ASSOCIATIVITY{DISTANT}};
            end
        end else begin
            if (state == AGE) begin
                for (int w = 0; w < ASSOCIATIVITY; w++) begin
                    rrpv[lat_index][w] <= rrpv[lat_index][w] + M'(1);
                end
            end
            if (bus.hit_valid) begin
                rrpv[bus.hit_index][bus.hit_way] <= IMMEDIATE;
            end
            if (state == INSTALL) begin
                rrpv[lat_index][lat_way] <= lat_rrpv;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore)
    // ------------------------------------------------------------------
    assign bus.miss_ready   = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.victim_valid = (state == INSTALL);
    assign bus.victim_way   = lat_way;

endmodule

// File: tb/tb_rrip_victim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rrip_victim_sequencer
//   Directed bench for rrip_victim_sequencer. Inputs are driven 1ns after the
//   rising edge and outputs sampled at the same point; "cycle T+n" below is
//   the cycle after the n-th rising edge following acceptance in cycle T.
//   Expected RRPV contents and latencies are hand-derived constants.
// ---------------------------------------------------------------------------
module tb_rrip_victim_sequencer;
    localparam int ASSOC = 4;
    localparam int SS    = 2;
    localparam int DEPTH = 64;
    localparam int IW    = 6;
    localparam int M     = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   errs   = 0;
    int   checks = 0;

    rrip_victim_sequencer_if #(.SET_SIZE(SS), .INDEX_WIDTH(IW), .M(M)) bus();

    rrip_victim_sequencer #(
        .ASSOCIATIVITY(ASSOC), .SET_SIZE(SS), .DEPTH(DEPTH),
        .INDEX_WIDTH(IW), .M(M)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_set(input string tag, input int s, input int e [4]);
        for (int w = 0; w < ASSOC; w++) begin
            chk($sformatf("%s_rrpv_s%0d_w%0d", tag, s, w), 32'(dut.rrpv[s][w]), e[w]);
        end
    endtask

    task automatic hit(input int s, input int w);
        bus.hit_valid = 1'b1;
        bus.hit_index = IW'(s);
        bus.hit_way   = SS'(w);
        tick();
        bus.hit_valid = 1'b0;
    endtask

    // One miss on set idx; optional hit on the same set at cycle offset
    // hit_at (-1 for none). Request inputs are scrambled after T to show
    // they are latched.
    task automatic run_miss(input string tag, input int idx, input int rr,
                            input int hit_at, input int hway,
                            input int exp_way, input int exp_lat);
        int lat;
        int way;
        bus.miss_req   = 1'b1;
        bus.miss_index = IW'(idx);
        bus.ins_rrpv   = M'(rr);
        chk({tag, "_ready_at_T"}, 32'(bus.miss_ready), 1);
        lat = -1;
        way = 0;
        for (int off = 0; off < 24; off++) begin
            if (off > 0) begin
                tick();
                bus.miss_req   = 1'b0;
                bus.miss_index = IW'(idx ^ 1);
                bus.ins_rrpv   = ~M'(rr);
            end
            if (off == 1) chk({tag, "_busy_T1"}, 32'(bus.busy), 1);
            bus.hit_valid = (off == hit_at);
            bus.hit_index = IW'(idx);
            bus.hit_way   = SS'(hway);
            if (bus.victim_valid) begin
                lat = off;
                way = int'(bus.victim_way);
                break;
            end
        end
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_way"}, way, exp_way);
        tick();
        bus.hit_valid = 1'b0;
        chk({tag, "_ready_after"}, 32'(bus.miss_ready), 1);
        chk({tag, "_vv_low_after"}, 32'(bus.victim_valid), 0);
    endtask

    initial begin
        int n, c1, c2, w1, w2, rdy3;

        rst_n          = 1'b0;
        bus.hit_valid  = 1'b0;
        bus.hit_index  = '0;
        bus.hit_way    = '0;
        bus.miss_req   = 1'b0;
        bus.miss_index = '0;
        bus.ins_rrpv   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_miss_ready", 32'(bus.miss_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_victim_valid", 32'(bus.victim_valid), 0);
        chk("rst_victim_way", 32'(bus.victim_way), 0);
        chk_set("rst", 3, '{3, 3, 3, 3});
        chk_set("rst", 63, '{3, 3, 3, 3});

        // Plain miss on a fresh set: way 0 at T+2
        run_miss("s3_first", 3, 2, -1, 0, 0, 2);
        chk_set("s3_first", 3, '{2, 3, 3, 3});

        // Fill set 3, then one aging round
        run_miss("s3_w1", 3, 2, -1, 0, 1, 2);
        run_miss("s3_w2", 3, 2, -1, 0, 2, 2);
        run_miss("s3_w3", 3, 2, -1, 0, 3, 2);
        chk_set("s3_full", 3, '{2, 2, 2, 2});
        run_miss("s3_age1", 3, 2, -1, 0, 0, 4);
        chk_set("s3_age1", 3, '{2, 3, 3, 3});

        // Set 5 all IMMEDIATE via hits: three aging rounds
        for (int w = 0; w < ASSOC; w++) hit(5, w);
        chk_set("s5_hits", 5, '{0, 0, 0, 0});
        run_miss("s5_age3", 5, 1, -1, 0, 0, 8);
        chk_set("s5_age3", 5, '{1, 3, 3, 3});

        // Set 7 all 2, hit way 0 in the AGE cycle (T+2)
        for (int w = 0; w < ASSOC; w++) run_miss($sformatf("s7_fill%0d", w), 7, 2, -1, 0, w, 2);
        run_miss("s7_hit_age", 7, 1, 2, 0, 1, 4);
        chk_set("s7_hit_age", 7, '{0, 1, 3, 3});

        // Hit + INSTALL, same way: install value wins
        run_miss("s13_same", 13, 1, 2, 0, 0, 2);
        chk_set("s13_same", 13, '{1, 3, 3, 3});
        // Hit + INSTALL, different way: both applied
        run_miss("s13_diff", 13, 1, 2, 3, 1, 2);
        chk_set("s13_diff", 13, '{1, 1, 3, 0});

        // Hit in the accept cycle is visible to the first SCAN
        run_miss("s15_hit_acc", 15, 2, 0, 0, 1, 2);
        chk_set("s15_hit_acc", 15, '{0, 2, 3, 3});

        // miss_req held high: accepts at T and T+3 only
        bus.miss_req   = 1'b1;
        bus.miss_index = IW'(9);
        bus.ins_rrpv   = M'(2);
        n = 0; c1 = -1; c2 = -1; w1 = -1; w2 = -1; rdy3 = -1;
        for (int off = 0; off < 8; off++) begin
            if (off > 0) tick();
            if (off == 6) bus.miss_req = 1'b0;
            if (off == 3) rdy3 = int'(bus.miss_ready);
            if (bus.victim_valid) begin
                n++;
                if (n == 1) begin c1 = off; w1 = int'(bus.victim_way); end
                if (n == 2) begin c2 = off; w2 = int'(bus.victim_way); end
            end
        end
        chk("hold_pulses", n, 2);
        chk("hold_first_cycle", c1, 2);
        chk("hold_first_way", w1, 0);
        chk("hold_ready_T3", rdy3, 1);
        chk("hold_second_cycle", c2, 5);
        chk("hold_second_way", w2, 1);
        chk("hold_idle_end", 32'(bus.miss_ready), 1);
        chk_set("hold", 9, '{2, 2, 3, 3});

        // Reset at T+3 of an all-zero miss aborts it
        for (int w = 0; w < ASSOC; w++) hit(11, w);
        bus.miss_req   = 1'b1;
        bus.miss_index = IW'(11);
        bus.ins_rrpv   = M'(1);
        n = 0;
        for (int off = 0; off < 12; off++) begin
            if (off > 0) begin
                tick();
                bus.miss_req = 1'b0;
            end
            if (off == 3) rst_n = 1'b0;
            if (off == 4) rst_n = 1'b1;
            if (bus.victim_valid) n++;
        end
        chk("abort_no_victim", n, 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk_set("abort", 11, '{3, 3, 3, 3});
        chk_set("abort", 3, '{3, 3, 3, 3});
        chk_set("abort", 5, '{3, 3, 3, 3});
        run_miss("post_abort", 11, 0, -1, 0, 0, 2);
        chk_set("post_abort", 11, '{0, 3, 3, 3});

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/rrip_victim_sequencer.md
Name: rrip_victim_sequencer

Overview:
- Per-set RRIP state owner and victim-selection controller for the set-associative caches in mips_core.
- Holds the M-bit RRPV array for every set and way.
- On a cache miss it runs a scan/age state machine to pick a victim way, then installs the insertion RRPV supplied by the SHiP predictor into that way.
- Hits promote the hit way to IMMEDIATE (RRPV 0). The block sits between the cache controller (hit/miss, index) and the SHiP predictor (insertion RRPV).

Parameters:
- ASSOCIATIVITY, 4, number of ways per set.
- SET_SIZE, 2, way-index width; equals $clog2(ASSOCIATIVITY).
- DEPTH, 64, number of sets.
- INDEX_WIDTH, 6, set-index width; equals $clog2(DEPTH).
- M, 2, RRPV width. DISTANT = 2^M-1, IMMEDIATE = 0.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous reset, active-low
- hit_valid  input  1  cache hit this cycle
- hit_index  input  INDEX_WIDTH  set of the hit
- hit_way  input  SET_SIZE  way of the hit
- miss_req  input  1  request victim selection
- miss_index  input  INDEX_WIDTH  set of the miss
- ins_rrpv  input  M  insertion RRPV from the predictor
- miss_ready  output  1  sequencer idle; a miss_req is accepted
- victim_valid  output  1  one-cycle pulse; victim_way is valid
- victim_way  output  SET_SIZE  selected way
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - every RRPV[way][set] = DISTANT;
  - FSM = IDLE; victim_valid = 0, victim_way = 0, busy = 0, miss_ready = 1 after the reset cycle.
- Reset asserted mid-operation aborts the operation: no victim_valid pulse and no RRPV write.
- Acceptance:
  - A miss is accepted when miss_req && miss_ready (cycle T).
  - miss_index and ins_rrpv are latched in cycle T; later changes are ignored.
  - miss_req while busy is ignored; it is not queued.
- FSM states: IDLE, SCAN, AGE, INSTALL.
  - IDLE: on accept -> SCAN.
  - SCAN: priority search of the latched set for RRPV==DISTANT, lowest way index wins.
    - Found: latch the way, -> INSTALL.
    - None found: -> AGE.
  - AGE: every way in the latched set gets RRPV+1. No saturation is needed, since no way is at DISTANT. -> SCAN.
  - INSTALL: victim_valid=1, victim_way=latched way; RRPV[way][set] <= latched ins_rrpv at the end of this cycle. -> IDLE.
- Latency:
  - victim_valid is asserted in cycle T+2+2k, where k = number of aging rounds (0 <= k <= 2^M-1).
  - miss_ready returns high in cycle T+3+2k.
- miss_ready = (state==IDLE). busy = !miss_ready.
- Hit update: when hit_valid is high, RRPV[hit_way][hit_index] <= 0 at the clock edge. Hits are processed in every FSM state.
- Simultaneous events:
  - Hit and AGE on the same set: the hit way goes to 0; the other ways age.
  - Hit and INSTALL on the same set and way: the install wins (ins_rrpv).
  - Hit and INSTALL on the same set, different way: both are applied.
  - Hit and accept in the same IDLE cycle: both proceed. SCAN in cycle T+1 sees the post-hit state.
- All RRPV arithmetic is M-bit unsigned. Aging only occurs when every way in the set is < DISTANT, so no wrap is possible.

Test Plan:
- Reset, then miss set 3, ins_rrpv=2 at T -> victim_valid at T+2, victim_way=0; RRPV[0][3]=2; miss_ready high at T+3.
- Fill set 3 ways 0..3 with ins_rrpv=2, then miss set 3 -> one aging round; victim_valid at T+4, way 0; ways 1..3 now 3.
- Set 5 all ways RRPV=0 (via hits), then miss -> three aging rounds; victim_valid at T+8, way 0.
- Set 5 all ways 2, hit way 0 in the AGE cycle -> RRPV[0]=0, others 3; victim way 1.
- miss_req held high through a busy window -> exactly one victim_valid per accept; a second accept only at the miss_ready cycle.
- rst_n low at T+3 during the all-zero scenario -> no victim_valid; all RRPV=DISTANT; the next miss gives the victim at +2 cycles, way 0.
